// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
// Stalls the pipeline for 33 cycles on the normal path and 1 cycle on divide-by-zero/overflow.
module ex_div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            valid_i,
    input  logic [4:0]      opcode,
    input  logic [2:0]      func3,
    input  logic [3:0]      func7,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] div_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [XLEN-1:0]   rem_r, quo_r, dvs_r, result_r;
    logic              neg_q_r, neg_r_r, is_rem_r;

    logic              is_div_s, start_s, signed_op_s, div_zero_s, ovf_s, last_step_s, ge_s;
    logic [XLEN:0]     shift_s, diff_s;
    logic [XLEN-1:0]   rem_nxt_s, quo_nxt_s;
    logic              unused_s;

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic en);
        return (en && v[XLEN-1]) ? negate(v) : v;
    endfunction

    assign is_div_s    = valid_i & (opcode == 5'b01100) & func7[0] & func3[2];
    assign start_s     = is_div_s & ~flush_i;
    assign signed_op_s = ~func3[0];
    assign div_zero_s  = (operand2 == {XLEN{1'b0}});
    assign ovf_s       = signed_op_s & (operand1 == {1'b1, {(XLEN-1){1'b0}}})
                         & (operand2 == {XLEN{1'b1}});
    assign last_step_s = (cnt_r == CNT_W'(XLEN-1));

    // One restoring step: shift in the next dividend bit and try to subtract the divisor.
    assign shift_s   = {rem_r, quo_r[XLEN-1]};
    assign ge_s      = (shift_s >= {1'b0, dvs_r});
    assign diff_s    = shift_s - {1'b0, dvs_r};
    assign rem_nxt_s = ge_s ? diff_s[XLEN-1:0] : shift_s[XLEN-1:0];
    assign quo_nxt_s = {quo_r[XLEN-2:0], ge_s};
    assign unused_s  = &{1'b0, func7[3:1], diff_s[XLEN]};

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and stall request; flush always returns to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        stall_o     = 1'b0;
        case (state_r)
            IDLE: begin
                stall_o = start_s;
                if (start_s) begin
                    state_nxt_s = (div_zero_s || ovf_s) ? DONE : CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                stall_o = 1'b1;
                if (flush_i) begin
                    state_nxt_s = IDLE;
                end else if (last_step_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            DONE: begin
                if (flush_i || !stall_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Operand latch, iteration datapath and result register with sign fix-up.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r    <= {CNT_W{1'b0}};
            rem_r    <= {XLEN{1'b0}};
            quo_r    <= {XLEN{1'b0}};
            dvs_r    <= {XLEN{1'b0}};
            result_r <= {XLEN{1'b0}};
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            is_rem_r <= 1'b0;
        end else if (state_r == IDLE && start_s) begin
            if (div_zero_s) begin
                result_r <= func3[1] ? operand1 : {XLEN{1'b1}};
            end else if (ovf_s) begin
                result_r <= func3[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
            end else begin
                quo_r    <= abs_val(operand1, signed_op_s);
                dvs_r    <= abs_val(operand2, signed_op_s);
                rem_r    <= {XLEN{1'b0}};
                cnt_r    <= {CNT_W{1'b0}};
                neg_q_r  <= signed_op_s & (operand1[XLEN-1] ^ operand2[XLEN-1]);
                neg_r_r  <= signed_op_s & operand1[XLEN-1];
                is_rem_r <= func3[1];
            end
        end else if (state_r == CALC && !flush_i) begin
            rem_r <= rem_nxt_s;
            quo_r <= quo_nxt_s;
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (last_step_s) begin
                if (is_rem_r) begin
                    result_r <= neg_r_r ? negate(rem_nxt_s) : rem_nxt_s;
                end else begin
                    result_r <= neg_q_r ? negate(quo_nxt_s) : quo_nxt_s;
                end
            end
        end
    end

    assign done_o  = (state_r == DONE);
    assign div_out = result_r;

endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
- Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU group.
- Sits in the EX stage beside the combinational ALU and takes the same opcode/func3/func7/operand inputs.
- The ALU returns 0 for R-type func7[0]=1, func3[2]=1; this block produces the real result and muxes into EX/MEM.
- Requests a pipeline stall while a division is in flight, then presents the result for capture.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  core clock
- rstn  input  1  asynchronous active-low reset
- valid_i  input  1  EX stage holds a valid instruction
- opcode  input  5  inst[6:2], same encoding the ALU uses
- func3  input  3  inst[14:12]
- func7  input  4  {inst[29], inst[27], inst[30], inst[25]}; bit 0 = inst[25]
- operand1  input  32  dividend (rs1, post-forwarding)
- operand2  input  32  divisor (rs2, post-forwarding)
- stall_i  input  1  downstream/global stall; EX/MEM not advancing
- flush_i  input  1  kill the EX instruction (branch/jump redirect)
- stall_o  output  1  divider needs EX held
- done_o  output  1  div_out valid this cycle
- div_out  output  32  quotient or remainder

Behaviour:
- is_div = valid_i & (opcode==5'b01100) & func7[0] & func3[2]. Ops by func3:
  - 100 DIV (signed quotient)
  - 101 DIVU
  - 110 REM (signed remainder)
  - 111 REMU
- Reset (rstn low, async): state=IDLE, counter=0, internal regs=0. stall_o=0, done_o=0, div_out=0.
- FSM states IDLE, CALC, DONE.
  - IDLE:
    - is_div & !flush_i & divisor==0 -> DONE. Result: quotient 32'hFFFF_FFFF; remainder = operand1.
    - is_div & !flush_i & signed op & operand1==32'h8000_0000 & operand2==32'hFFFF_FFFF -> DONE. Result: quotient 32'h8000_0000; remainder 0.
    - otherwise is_div & !flush_i -> CALC. Latch |dividend| and |divisor| (raw values for unsigned ops), quotient sign = sign1^sign2, remainder sign = sign1, op select. Clear partial remainder; counter=0.
  - CALC: one restoring step per cycle.
    - Shift {rem, quo} left 1; trial = rem - divisor (33-bit).
    - If trial non-negative: rem = trial, quo[0]=1; else quo[0]=0.
    - Counter increments; after step 32 (counter==31 at the edge) -> DONE.
    - Final sign fix-up is applied into the result register on that transition.
  - DONE: done_o=1, stall_o=0, div_out = registered result.
    - stall_i=1 -> hold DONE with result stable.
    - stall_i=0 -> IDLE next edge.
- stall_o (combinational) = (state==IDLE & is_div & !flush_i) | state==CALC. It is never high in DONE.
- Latency (EX entry = cycle 0):
  - Normal: stall_o high in cycles 0..32; done_o high in cycle 33 onward while stall_i=1.
  - Divide-by-zero / overflow: stall_o high in cycle 0 only; done_o in cycle 1.
- div_out holds its last value when not in DONE; consumers qualify it with done_o.
- flush_i:
  - In any state -> IDLE at next edge; done_o low from that edge.
  - In IDLE it blocks the start.
  - Flush wins over stall_i in DONE.
- Operands are latched at start; changes to operand1/operand2 during CALC are ignored.
- Back-to-back divides: DONE->IDLE takes one edge, and the next instruction is evaluated in IDLE. Identical operands still recompute; there is no result reuse.
- Non-div instructions: stall_o=0, done_o=0, FSM stays IDLE.
- A new is_div seen while in CALC or DONE is not restarted; the pipeline is stalled, so this does not occur legally.

Test Plan:
- DIV operand1=-7 (32'hFFFF_FFF9), operand2=2 -> stall_o high 33 cycles, then done_o=1, div_out=32'hFFFF_FFFD (-3). Same operands with REM -> 32'hFFFF_FFFF (-1).
- DIVU 32'hFFFF_FFFF / 16 -> 32'h0FFF_FFFF; REMU same -> 32'h0000_000F; latency 33 cycles each.
- Divide by zero: DIV 1234/0 -> 32'hFFFF_FFFF after 1 cycle; REMU 1234/0 -> 1234.
- Overflow DIV 32'h8000_0000 / 32'hFFFF_FFFF -> 32'h8000_0000, REM -> 0, one-cycle stall. Same operands with DIVU -> normal path, result 0.
- Hold and flush: hold stall_i=1 for 5 cycles in DONE -> div_out stable, done_o high throughout. Assert flush_i at CALC step 10 -> IDLE next edge, stall_o=0, no done_o.
- Reset mid-op: drop rstn at CALC step 20 -> all outputs 0 immediately. Release, then DIV 100/7 -> 14 after 33 cycles.
